// File: rtl/sram_line_fetch.sv
// sram_line_fetch
// Double-buffered background line fetcher. On each line_start the front and
// back line buffers swap roles. The requested line is then read from SRAM,
// one 16-bit word at a time, into the new back buffer. The display side reads
// 4-bit palette indices from the front buffer, with one cycle of latency.
//
// Ports
//   Clk          in   system clock
//   Reset        in   synchronous, active-high reset
//   line_start   in   one-cycle pulse: swap buffers and fetch line line_num
//   line_num     in   line to fetch (sampled only with line_start)
//   Read         out  level request to the SRAM controller
//   addr_in      out  SRAM word address for the current request
//   done_r       in   controller data-valid (two consecutive cycles per access)
//   OUTPUT_DATA  in   controller read data, valid while done_r=1
//   pix_x        in   display pixel column
//   pix_idx      out  palette index for pix_x, registered
//   busy         out  fetch in progress
//   overrun      out  one-cycle pulse when a line_start is dropped
module sram_line_fetch #(
    parameter logic [19:0] BASE_ADDR      = 20'h00000,
    parameter int          WORDS_PER_LINE = 160,
    parameter int          LINES          = 480
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        line_start,
    input  logic [8:0]  line_num,
    output logic        Read,
    output logic [19:0] addr_in,
    input  logic        done_r,
    input  logic [15:0] OUTPUT_DATA,
    input  logic [9:0]  pix_x,
    output logic [3:0]  pix_idx,
    output logic        busy,
    output logic        overrun
);

    localparam int WW           = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int PIX_PER_LINE = WORDS_PER_LINE * 4;
    localparam logic [WW-1:0] LAST_WORD = WW'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            front_sel_r;
    logic [8:0]      line_r;
    logic [WW-1:0]   word_r;
    logic            read_r;
    logic [19:0]     addr_r;
    logic            busy_r;
    logic            overrun_r;
    logic [3:0]      pix_idx_r;

    // Buffer 0 is front while front_sel_r=0; the other one is written by fetches.
    logic [15:0]     buf0_r [0:WORDS_PER_LINE-1];
    logic [15:0]     buf1_r [0:WORDS_PER_LINE-1];

    logic            line_ok_s;
    logic            start_s;
    logic            wr_en_s;
    logic            front_sel_nxt_s;
    logic [8:0]      line_nxt_s;
    logic [WW-1:0]   word_nxt_s;
    logic            read_nxt_s;
    logic [19:0]     addr_nxt_s;
    logic            busy_nxt_s;
    logic            overrun_nxt_s;
    logic            pix_in_line_s;
    logic [WW-1:0]   pix_word_s;
    logic [15:0]     front_word_s;
    logic [3:0]      pix_nibble_s;

    // SRAM word address of word w of a line; wraps modulo 2^20.
    function automatic logic [19:0] word_addr(input logic [8:0] line, input logic [WW-1:0] w);
        word_addr = BASE_ADDR + (20'(line) * 20'(WORDS_PER_LINE)) + 20'(w);
    endfunction

    assign line_ok_s = ({23'd0, line_num} < 32'(LINES));
    // Only a REQ-state access writes; the controller's second valid cycle lands in WAIT_LOW.
    assign wr_en_s   = (state_r == ST_REQ) && done_r && !Reset;

    // State register and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            front_sel_r <= 1'b0;
            line_r      <= 9'd0;
            word_r      <= {WW{1'b0}};
            read_r      <= 1'b0;
            addr_r      <= BASE_ADDR;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            front_sel_r <= front_sel_nxt_s;
            line_r      <= line_nxt_s;
            word_r      <= word_nxt_s;
            read_r      <= read_nxt_s;
            addr_r      <= addr_nxt_s;
            busy_r      <= busy_nxt_s;
            overrun_r   <= overrun_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (line_start && line_ok_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (done_r) begin
                    state_nxt_s = ST_WAIT_LOW;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT_LOW: begin
                if (done_r) begin
                    state_nxt_s = ST_WAIT_LOW;
                end else if (word_r == LAST_WORD) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        start_s         = (state_r == ST_IDLE) && line_start && line_ok_s;
        // A start while busy is dropped and reported; the running fetch is untouched.
        overrun_nxt_s   = (state_r != ST_IDLE) && line_start;
        front_sel_nxt_s = front_sel_r;
        line_nxt_s      = line_r;
        word_nxt_s      = word_r;
        read_nxt_s      = read_r;
        addr_nxt_s      = addr_r;
        busy_nxt_s      = busy_r;
        if (start_s) begin
            front_sel_nxt_s = ~front_sel_r;
            line_nxt_s      = line_num;
            word_nxt_s      = {WW{1'b0}};
            addr_nxt_s      = word_addr(line_num, {WW{1'b0}});
            read_nxt_s      = 1'b1;
            busy_nxt_s      = 1'b1;
        end else if (wr_en_s) begin
            read_nxt_s = 1'b0;
        end else if ((state_r == ST_WAIT_LOW) && !done_r) begin
            if (word_r == LAST_WORD) begin
                read_nxt_s = 1'b0;
                busy_nxt_s = 1'b0;
            end else begin
                word_nxt_s = word_r + WW'(1);
                addr_nxt_s = word_addr(line_r, word_r + WW'(1));
                read_nxt_s = 1'b1;
            end
        end else begin
            read_nxt_s = read_r;
        end
    end

    // Back-buffer write; buffer contents are deliberately not reset
    always_ff @(posedge Clk) begin
        if (wr_en_s) begin
            if (front_sel_r) begin
                buf0_r[word_r] <= OUTPUT_DATA;
            end else begin
                buf1_r[word_r] <= OUTPUT_DATA;
            end
        end
    end

    // Front-buffer nibble select; columns past the line read as index 0
    always_comb begin
        pix_in_line_s = ({22'd0, pix_x} < 32'(PIX_PER_LINE));
        if (pix_in_line_s) begin
            pix_word_s = WW'(pix_x[9:2]);
        end else begin
            pix_word_s = {WW{1'b0}};
        end
        if (front_sel_r) begin
            front_word_s = buf1_r[pix_word_s];
        end else begin
            front_word_s = buf0_r[pix_word_s];
        end
        case (pix_x[1:0])
            2'd0:    pix_nibble_s = front_word_s[15:12];
            2'd1:    pix_nibble_s = front_word_s[11:8];
            2'd2:    pix_nibble_s = front_word_s[7:4];
            2'd3:    pix_nibble_s = front_word_s[3:0];
            default: pix_nibble_s = 4'd0;
        endcase
        if (!pix_in_line_s) begin
            pix_nibble_s = 4'd0;
        end else begin
            pix_nibble_s = pix_nibble_s;
        end
    end

    // Registered palette index
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_idx_r <= 4'd0;
        end else begin
            pix_idx_r <= pix_nibble_s;
        end
    end

    assign Read    = read_r;
    assign addr_in = addr_r;
    assign busy    = busy_r;
    assign overrun = overrun_r;
    assign pix_idx = pix_idx_r;

endmodule

// File: tb/tb_sram_line_fetch.sv
// Testbench for sram_line_fetch: a behavioural SRAM controller returns
// data = address[15:0]. A line-level model tracks which line's words sit in
// each physical buffer, and which buffer is the front one.
module tb_sram_line_fetch;

    localparam int WPL    = 160;
    localparam int NLINES = 480;
    localparam int BASE   = 0;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        line_start = 1'b0;
    logic [8:0]  line_num = 9'd0;
    logic        Read;
    logic [19:0] addr_in;
    logic        done_r = 1'b0;
    logic [15:0] OUTPUT_DATA = 16'd0;
    logic [9:0]  pix_x = 10'd0;
    logic [3:0]  pix_idx;
    logic        busy;
    logic        overrun;

    always #5 Clk = ~Clk;

    sram_line_fetch dut (
        .Clk(Clk), .Reset(Reset), .line_start(line_start), .line_num(line_num),
        .Read(Read), .addr_in(addr_in), .done_r(done_r), .OUTPUT_DATA(OUTPUT_DATA),
        .pix_x(pix_x), .pix_idx(pix_idx), .busy(busy), .overrun(overrun)
    );

    int tests = 0;
    int fails = 0;

    // controller model state
    int          ph = 0;
    int          lat = 0;
    logic [19:0] cap = 20'd0;
    bit          ctrl_chk = 1'b1;
    logic [19:0] req_q [$];
    int          done_cnt = 0;
    int          hold_viol = 0;
    int          ov_cnt = 0;

    // line-level reference model
    logic [15:0] mbuf [2][WPL];
    bit          mval [2][WPL];
    int          mfront = 0;
    int          cur_line = 0;
    int          fetch_done0 = 0;
    int          fetch_hv0 = 0;

    function automatic logic [19:0] line_addr(input int ln, input int k);
        int a;
        a = BASE + ln * WPL + k;
        return 20'(a);
    endfunction

    // SRAM controller: one access per Read request, done_r high two cycles
    always @(negedge Clk) begin
        case (ph)
            0: begin
                if (Read === 1'b1) begin
                    cap = addr_in;
                    req_q.push_back(addr_in);
                    lat = int'($urandom_range(0, 2));
                    if (lat == 0) begin
                        done_r = 1'b1; OUTPUT_DATA = cap[15:0]; done_cnt++; ph = 2;
                    end else begin
                        ph = 1;
                    end
                end
            end
            1: begin
                if (ctrl_chk && (Read !== 1'b1 || addr_in !== cap)) hold_viol++;
                lat--;
                if (lat == 0) begin
                    done_r = 1'b1; OUTPUT_DATA = cap[15:0]; done_cnt++; ph = 2;
                end
            end
            2: begin
                if (ctrl_chk && Read !== 1'b0) hold_viol++;
                ph = 3;
            end
            3: begin
                done_r = 1'b0;
                OUTPUT_DATA = 16'($urandom);
                if (ctrl_chk && Read !== 1'b0) hold_viol++;
                ph = 0;
            end
            default: ph = 0;
        endcase
    end

    // overrun pulse counter
    always @(negedge Clk) begin
        if (overrun === 1'b1) ov_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    task automatic start_fetch(input int ln, input string nm);
        req_q.delete();
        fetch_done0 = done_cnt;
        fetch_hv0 = hold_viol;
        cur_line = ln;
        line_start = 1'b1;
        line_num = 9'(ln);
        step();
        line_start = 1'b0;
        line_num = 9'($urandom);
        mfront ^= 1;
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL %s_busy_rise: got %b expected 1", nm, busy); end
    endtask

    task automatic finish_fetch(input string nm);
        int n; int bad; int first_bad; logic [19:0] ea; int bk;
        n = 0;
        while (busy !== 1'b0 && n < 4000) begin step(); n++; end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL %s_busy_fall: got %b expected 0 within 4000 cycles", nm, busy); end
        tests++;
        if (req_q.size() != WPL) begin fails++; $display("FAIL %s_req_count: got %0d expected %0d", nm, req_q.size(), WPL); end
        bad = 0; first_bad = 0;
        for (int k = 0; k < req_q.size() && k < WPL; k++) begin
            if (req_q[k] !== line_addr(cur_line, k)) begin
                if (bad == 0) first_bad = k;
                bad++;
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s_addr_seq: word %0d got %0h expected %0h (%0d wrong)", nm, first_bad, req_q[first_bad], line_addr(cur_line, first_bad), bad);
        end
        tests++;
        if (done_cnt - fetch_done0 != WPL) begin fails++; $display("FAIL %s_done_count: got %0d expected %0d", nm, done_cnt - fetch_done0, WPL); end
        tests++;
        if (hold_viol != fetch_hv0) begin fails++; $display("FAIL %s_read_hold: got %0d violations expected 0", nm, hold_viol - fetch_hv0); end
        tests++;
        if (addr_in !== line_addr(cur_line, WPL - 1)) begin fails++; $display("FAIL %s_idle_addr: got %0h expected %0h", nm, addr_in, line_addr(cur_line, WPL - 1)); end
        bk = mfront ^ 1;
        for (int k = 0; k < WPL; k++) begin
            ea = line_addr(cur_line, k);
            mbuf[bk][k] = ea[15:0];
            mval[bk][k] = 1'b1;
        end
    endtask

    task automatic check_pixels(input int n, input string nm);
        logic [9:0] px; logic [15:0] wd; logic [3:0] ex; int wi; int sh;
        for (int i = 0; i < n; i++) begin
            if (i < 4) px = 10'(i);
            else if (i % 6 == 5) px = 10'($urandom_range(640, 1023));
            else px = 10'($urandom_range(0, 639));
            pix_x = px;
            step();
            if (px >= 10'd640) begin
                tests++;
                if (pix_idx !== 4'd0) begin fails++; $display("FAIL %s_pix_off: x=%0d got %h expected 0", nm, px, pix_idx); end
            end else begin
                wi = int'(px) / 4;
                if (mval[mfront][wi]) begin
                    wd = mbuf[mfront][wi];
                    sh = 12 - 4 * (int'(px) % 4);
                    ex = 4'(wd >> sh);
                    tests++;
                    if (pix_idx !== ex) begin fails++; $display("FAIL %s_pix: x=%0d got %h expected %h", nm, px, pix_idx, ex); end
                end
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; line_start = 1'b0; line_num = 9'd0; pix_x = 10'd0;
        step(); step();
        tests++; if (Read !== 1'b0) begin fails++; $display("FAIL reset_read: got %b expected 0", Read); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        tests++; if (pix_idx !== 4'd0) begin fails++; $display("FAIL reset_pix: got %h expected 0", pix_idx); end
        tests++; if (addr_in !== 20'h00000) begin fails++; $display("FAIL reset_addr: got %h expected 00000", addr_in); end
        Reset = 1'b0;
        mfront = 0;
    endtask

    task automatic test_line_fetch();
        start_fetch(2, "line2");
        finish_fetch("line2");
        start_fetch(7, "line7");
        pix_x = 10'd5;
        step();
        tests++;
        if (pix_idx !== 4'h1) begin fails++; $display("FAIL line2_pix5: got %h expected 1", pix_idx); end
        check_pixels(30, "line2_front");
        finish_fetch("line7");
        check_pixels(12, "line2_after");
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            start_fetch(int'($urandom_range(0, NLINES - 1)), "b2b");
            check_pixels(20, "b2b_front");
            finish_fetch("b2b");
        end
    endtask

    task automatic test_overrun();
        int n; int ov0;
        start_fetch(int'($urandom_range(0, NLINES - 1)), "ovr");
        n = 0;
        while (req_q.size() < 41 && n < 2000) begin step(); n++; end
        tests++;
        if (req_q.size() < 41) begin fails++; $display("FAIL ovr_reach_word40: got %0d requests expected 41", req_q.size()); end
        ov0 = ov_cnt;
        line_start = 1'b1;
        line_num = 9'($urandom_range(0, NLINES - 1));
        step();
        line_start = 1'b0;
        step(); step();
        tests++;
        if (ov_cnt - ov0 != 1) begin fails++; $display("FAIL ovr_pulse: got %0d cycles expected 1", ov_cnt - ov0); end
        check_pixels(16, "ovr_front");
        finish_fetch("ovr");
        tests++;
        if (ov_cnt - ov0 != 1) begin fails++; $display("FAIL ovr_total: got %0d cycles expected 1", ov_cnt - ov0); end
    endtask

    task automatic test_out_of_range();
        int viol; int q0; int ov0; int lv;
        for (int r = 0; r < 2; r++) begin
            lv = (r == 0) ? NLINES : int'($urandom_range(NLINES + 1, 511));
            q0 = req_q.size(); ov0 = ov_cnt; viol = 0;
            line_start = 1'b1;
            line_num = 9'(lv);
            step();
            line_start = 1'b0;
            for (int c = 0; c < 6; c++) begin
                if (Read !== 1'b0 || busy !== 1'b0) viol++;
                step();
            end
            tests++; if (viol != 0) begin fails++; $display("FAIL oor_read_busy: line %0d got %0d active cycles expected 0", lv, viol); end
            tests++; if (ov_cnt != ov0) begin fails++; $display("FAIL oor_overrun: got %0d pulses expected 0", ov_cnt - ov0); end
            tests++; if (req_q.size() != q0) begin fails++; $display("FAIL oor_requests: got %0d expected %0d", req_q.size() - q0, 0); end
        end
        check_pixels(16, "oor_front");
    endtask

    task automatic test_reset_mid_fetch();
        int n; int viol; int bk; logic [19:0] ea;
        start_fetch(int'($urandom_range(0, NLINES - 1)), "rst");
        n = 0;
        while (req_q.size() < 51 && n < 2000) begin step(); n++; end
        tests++;
        if (req_q.size() < 51 || Read !== 1'b1) begin fails++; $display("FAIL rst_reach_word50: got %0d requests expected 51", req_q.size()); end
        Reset = 1'b1;
        ctrl_chk = 1'b0;
        step();
        tests++; if (Read !== 1'b0) begin fails++; $display("FAIL rst_mid_read: got %b expected 0", Read); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        tests++; if (pix_idx !== 4'd0) begin fails++; $display("FAIL rst_mid_pix: got %h expected 0", pix_idx); end
        Reset = 1'b0;
        bk = mfront ^ 1;
        for (int k = 0; k < 50; k++) begin
            ea = line_addr(cur_line, k);
            mbuf[bk][k] = ea[15:0];
            mval[bk][k] = 1'b1;
        end
        mval[bk][50] = 1'b0;
        mfront = 0;
        viol = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (Read !== 1'b0 || busy !== 1'b0) viol++;
        end
        tests++; if (viol != 0) begin fails++; $display("FAIL rst_stays_idle: got %0d active cycles expected 0", viol); end
        tests++; if (addr_in !== 20'(BASE)) begin fails++; $display("FAIL rst_addr: got %h expected %h", addr_in, 20'(BASE)); end
        ctrl_chk = 1'b1;
        start_fetch(int'($urandom_range(0, NLINES - 1)), "after_rst");
        check_pixels(40, "after_rst_front");
        finish_fetch("after_rst");
        start_fetch(int'($urandom_range(0, NLINES - 1)), "final");
        check_pixels(40, "final_front");
        finish_fetch("final");
    endtask

    initial begin
        test_reset();
        test_line_fetch();
        test_back_to_back();
        test_overrun();
        test_out_of_range();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
